// File: rtl/axi_dc_isolate_pkg.sv
// Shared types and helpers for the AXI clock-domain-crossing isolation sequencer.
// Holds the sequencer state encoding and the counter-width helper.
// No logic, so no latency or backpressure of its own.
package axi_dc_isolate_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        ISOLATED = 2'd2
    } iso_state_e;

    // Bits needed to hold values 0..n inclusive; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/axi_ot_counter.sv
// Up/down outstanding-transaction counter: saturates at 0, synchronous clear.
// Count updates one cycle after inc/dec; count_nxt_o is the same-cycle next value.
// No backpressure; the caller must block increments at its own maximum.
module axi_ot_counter #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic [W-1:0] count_nxt_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && !dec_i) begin
            count_d = count_q + W'(1);
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            // A response with nothing outstanding is a protocol error; hold at 0.
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o     = count_q;
    assign count_nxt_o = count_d;

endmodule

// File: rtl/axi_dc_isolate_ctrl.sv
// Drains and isolates the SoC side of a dual-clock AXI slice before remote gating.
// isolate_o rises one cycle after the request when idle; AW/AR gating acts the cycle after.
// AW/AR ready/valid are forced low outside RUN or at MAX_OT outstanding; W/B/R pass untouched.
module axi_dc_isolate_ctrl
    import axi_dc_isolate_pkg::*;
#(
    parameter int MAX_OT  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         isolate_req_i,
    output logic                         isolate_o,
    output logic                         isolate_ack_o,
    output logic                         timeout_o,
    input  logic                         slv_aw_valid_i,
    output logic                         slv_aw_ready_o,
    output logic                         mst_aw_valid_o,
    input  logic                         mst_aw_ready_i,
    input  logic                         slv_ar_valid_i,
    output logic                         slv_ar_ready_o,
    output logic                         mst_ar_valid_o,
    input  logic                         mst_ar_ready_i,
    input  logic                         b_valid_i,
    input  logic                         b_ready_i,
    input  logic                         r_valid_i,
    input  logic                         r_ready_i,
    input  logic                         r_last_i,
    output logic [cnt_width(MAX_OT)-1:0] wr_ot_o,
    output logic [cnt_width(MAX_OT)-1:0] rd_ot_o
);

    localparam int OTW = cnt_width(MAX_OT);
    localparam int TW  = cnt_width(TIMEOUT);
    localparam logic [OTW-1:0] OT_MAX = OTW'(MAX_OT);
    localparam logic [TW-1:0]  T_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    iso_state_e    state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          timeout_q, timeout_d;
    logic          isolate_q, isolate_d;

    logic [OTW-1:0] wr_ot, rd_ot, wr_ot_nxt, rd_ot_nxt;
    logic           open_aw, open_ar;
    logic           aw_hs, ar_hs, b_hs, r_last_hs;
    logic           ot_clr;

    assign open_aw = (state_q == RUN) && (wr_ot < OT_MAX);
    assign open_ar = (state_q == RUN) && (rd_ot < OT_MAX);

    assign mst_aw_valid_o = slv_aw_valid_i & open_aw;
    assign slv_aw_ready_o = mst_aw_ready_i & open_aw;
    assign mst_ar_valid_o = slv_ar_valid_i & open_ar;
    assign slv_ar_ready_o = mst_ar_ready_i & open_ar;

    assign aw_hs     = mst_aw_valid_o & mst_aw_ready_i;
    assign ar_hs     = mst_ar_valid_o & mst_ar_ready_i;
    assign b_hs      = b_valid_i & b_ready_i;
    assign r_last_hs = r_valid_i & r_ready_i & r_last_i;

    // Leaving isolation: the wrapper swallowed whatever responses were pending.
    assign ot_clr = (state_q == ISOLATED) && !isolate_req_i;

    axi_ot_counter #(.W(OTW)) u_wr_ot (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (ot_clr),
        .inc_i       (aw_hs),
        .dec_i       (b_hs),
        .count_o     (wr_ot),
        .count_nxt_o (wr_ot_nxt)
    );

    axi_ot_counter #(.W(OTW)) u_rd_ot (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (ot_clr),
        .inc_i       (ar_hs),
        .dec_i       (r_last_hs),
        .count_o     (rd_ot),
        .count_nxt_o (rd_ot_nxt)
    );

    // Decisions use next-cycle counts so a handshake in the request cycle still drains.
    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        timeout_d = timeout_q;
        unique case (state_q)
            RUN: begin
                tcnt_d = '0;
                if (isolate_req_i) begin
                    if ((wr_ot_nxt == '0) && (rd_ot_nxt == '0)) begin
                        state_d = ISOLATED;
                    end else begin
                        state_d   = DRAIN;
                        timeout_d = 1'b0;
                    end
                end
            end
            DRAIN: begin
                tcnt_d = tcnt_q + TW'(1);
                if (!isolate_req_i) begin
                    state_d = RUN;
                end else if ((wr_ot_nxt == '0) && (rd_ot_nxt == '0)) begin
                    state_d = ISOLATED;
                end else if ((TIMEOUT != 0) && (tcnt_q == T_LAST)) begin
                    state_d   = ISOLATED;
                    timeout_d = 1'b1;
                end
            end
            ISOLATED: begin
                if (!isolate_req_i) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        isolate_d = (state_d == ISOLATED);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= RUN;
            tcnt_q    <= '0;
            timeout_q <= 1'b0;
            isolate_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            timeout_q <= timeout_d;
            isolate_q <= isolate_d;
        end
    end

    assign isolate_o     = isolate_q;
    assign isolate_ack_o = isolate_q;
    assign timeout_o     = timeout_q;
    assign wr_ot_o       = wr_ot;
    assign rd_ot_o       = rd_ot;

endmodule

// File: tb/tb_axi_dc_isolate_ctrl.sv
// Directed bench for axi_dc_isolate_ctrl with MAX_OT=8, TIMEOUT=16.
module tb_axi_dc_isolate_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       isolate_req;
    logic       isolate, isolate_ack, timeout;
    logic       slv_aw_valid, slv_aw_ready, mst_aw_valid, mst_aw_ready;
    logic       slv_ar_valid, slv_ar_ready, mst_ar_valid, mst_ar_ready;
    logic       b_valid, b_ready, r_valid, r_ready, r_last;
    logic [3:0] wr_ot, rd_ot;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_dc_isolate_ctrl #(.MAX_OT(8), .TIMEOUT(16)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .isolate_req_i  (isolate_req),
        .isolate_o      (isolate),
        .isolate_ack_o  (isolate_ack),
        .timeout_o      (timeout),
        .slv_aw_valid_i (slv_aw_valid),
        .slv_aw_ready_o (slv_aw_ready),
        .mst_aw_valid_o (mst_aw_valid),
        .mst_aw_ready_i (mst_aw_ready),
        .slv_ar_valid_i (slv_ar_valid),
        .slv_ar_ready_o (slv_ar_ready),
        .mst_ar_valid_o (mst_ar_valid),
        .mst_ar_ready_i (mst_ar_ready),
        .b_valid_i      (b_valid),
        .b_ready_i      (b_ready),
        .r_valid_i      (r_valid),
        .r_ready_i      (r_ready),
        .r_last_i       (r_last),
        .wr_ot_o        (wr_ot),
        .rd_ot_o        (rd_ot)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; isolate_req = 1'b0;
        slv_aw_valid = 1'b0; mst_aw_ready = 1'b1;
        slv_ar_valid = 1'b0; mst_ar_ready = 1'b1;
        b_valid = 1'b0; b_ready = 1'b1;
        r_valid = 1'b0; r_ready = 1'b1; r_last = 1'b0;
        tick(2);
        rst = 1'b0;
        chk("rst_isolate", isolate, 0);
        chk("rst_ack", isolate_ack, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_wr_ot", wr_ot, 0);
        chk("rst_rd_ot", rd_ot, 0);
        chk("rst_aw_ready", slv_aw_ready, 1);

        // R last with nothing outstanding must not wrap
        r_valid = 1'b1; r_last = 1'b1;
        tick();
        r_valid = 1'b0; r_last = 1'b0;
        chk("rd_underflow", rd_ot, 0);

        // Idle isolation: one cycle
        isolate_req = 1'b1;
        tick();
        chk("idle_isolate", isolate, 1);
        chk("idle_ack", isolate_ack, 1);
        chk("idle_timeout", timeout, 0);
        chk("idle_aw_ready", slv_aw_ready, 0);
        isolate_req = 1'b0;
        tick();
        chk("idle_release", isolate, 0);
        chk("idle_release_aw_ready", slv_aw_ready, 1);

        // Three writes outstanding, then drain with B
        slv_aw_valid = 1'b1;
        tick(3);
        slv_aw_valid = 1'b0;
        chk("wr3_count", wr_ot, 3);
        isolate_req = 1'b1;
        tick();
        slv_aw_valid = 1'b1;
        #1;
        chk("wr3_aw_ready_blocked", slv_aw_ready, 0);
        chk("wr3_mst_aw_valid_blocked", mst_aw_valid, 0);
        chk("wr3_drain_isolate", isolate, 0);
        slv_aw_valid = 1'b0;
        b_valid = 1'b1;
        tick(2);
        chk("wr3_after_2b_isolate", isolate, 0);
        chk("wr3_after_2b_count", wr_ot, 1);
        tick();
        b_valid = 1'b0;
        chk("wr3_after_3b_isolate", isolate, 1);
        chk("wr3_after_3b_count", wr_ot, 0);
        chk("wr3_timeout", timeout, 0);
        isolate_req = 1'b0;
        tick();

        // AR accepted in the request cycle, 4-beat burst drains it
        slv_ar_valid = 1'b1; isolate_req = 1'b1;
        tick();
        slv_ar_valid = 1'b0;
        chk("rd_req_cycle_count", rd_ot, 1);
        chk("rd_req_cycle_isolate", isolate, 0);
        r_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("rd_beat_isolate", isolate, 0);
        end
        r_last = 1'b1;
        tick();
        r_valid = 1'b0; r_last = 1'b0;
        chk("rd_last_isolate", isolate, 1);
        chk("rd_last_count", rd_ot, 0);
        isolate_req = 1'b0;
        tick();

        // MAX_OT reads block further AR in RUN
        slv_ar_valid = 1'b1;
        tick(8);
        chk("rd_max_count", rd_ot, 8);
        chk("rd_max_ready", slv_ar_ready, 0);
        chk("rd_max_mst_valid", mst_ar_valid, 0);
        tick();
        chk("rd_max_hold", rd_ot, 8);
        slv_ar_valid = 1'b0;
        r_valid = 1'b1; r_last = 1'b1;
        tick();
        chk("rd_max_minus1", rd_ot, 7);
        chk("rd_max_ready_back", slv_ar_ready, 1);
        tick(7);
        r_valid = 1'b0; r_last = 1'b0;
        chk("rd_drained", rd_ot, 0);

        // Timeout with one B withheld
        slv_aw_valid = 1'b1;
        tick();
        slv_aw_valid = 1'b0;
        isolate_req = 1'b1;
        tick();
        chk("to_entry_isolate", isolate, 0);
        tick(15);
        chk("to_15_isolate", isolate, 0);
        chk("to_15_timeout", timeout, 0);
        tick();
        chk("to_16_isolate", isolate, 1);
        chk("to_16_timeout", timeout, 1);
        chk("to_16_wr_ot", wr_ot, 1);
        isolate_req = 1'b0;
        tick();
        chk("to_release_isolate", isolate, 0);
        chk("to_release_wr_ot", wr_ot, 0);
        chk("to_release_sticky", timeout, 1);

        // Simultaneous AW and B keep the count
        slv_aw_valid = 1'b1;
        tick(2);
        chk("same_pre", wr_ot, 2);
        b_valid = 1'b1;
        tick();
        slv_aw_valid = 1'b0; b_valid = 1'b0;
        chk("same_cycle_hold", wr_ot, 2);

        // Request dropped in DRAIN returns to RUN; new DRAIN clears timeout
        isolate_req = 1'b1;
        tick();
        chk("drop_drain_timeout_clr", timeout, 0);
        chk("drop_drain_aw_ready", slv_aw_ready, 0);
        isolate_req = 1'b0;
        tick();
        slv_aw_valid = 1'b1;
        #1;
        chk("drop_run_aw_ready", slv_aw_ready, 1);
        chk("drop_run_isolate", isolate, 0);
        tick();
        slv_aw_valid = 1'b0;
        chk("drop_run_aw_count", wr_ot, 3);

        // Reset mid-operation
        isolate_req = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        isolate_req = 1'b0;
        chk("midrst_wr_ot", wr_ot, 0);
        chk("midrst_isolate", isolate, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
